// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream request side (decode / register-file read,
// immediate, PC, select codes, forwarding source, flush) and the downstream
// operand side (A, B, store_data) with its valid/ready handshake.
// The master modport drives requests and accepts results; the slave
// modport is the operand stage itself.
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic            fwd_valid;
    logic [RAW-1:0]  fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] store_data;

    modport master (
        output in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, pc,
               a_sel, b_sel, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
        input  in_ready, out_valid, A, B, store_data
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, pc,
               a_sel, b_sel, fwd_valid, fwd_rd, fwd_data, flush, out_ready,
        output in_ready, out_valid, A, B, store_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects operands A and B (plus the resolved rs2 value
// for stores) and registers them into a two-entry skid buffer (OUT + SKID)
// with valid/ready handshake, flush and synchronous active-high reset.
//
// Optional feature macro: ALU_OPND_FWD_EN
//   defined   -> EX-result forwarding onto rs1/rs2 at accept time (x0 never
//                forwarded, buffered entries are not re-forwarded)
//   undefined -> fwd_* inputs are ignored
//
// Occupancy FSM:
//   state     | meaning
//   OCC_EMPTY | OUT and SKID empty, out_valid=0
//   OCC_ONE   | OUT holds the head entry, SKID empty
//   OCC_TWO   | OUT and SKID both full, in_ready=0
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_stage_if.slave   bus
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
    } opnd_t;

    logic [1:0] occ_q, occ_d;
    opnd_t      out_q, out_d;
    opnd_t      skid_q, skid_d;

    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    opnd_t           req;
    logic            accept;
    logic            transfer;

`ifdef ALU_OPND_FWD_EN
    logic fwd_hit1;
    logic fwd_hit2;

    // Forward the EX result onto a source register that matches it, never onto x0.
    always_comb begin
        fwd_hit1 = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.rs1_addr);
        fwd_hit2 = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.rs2_addr);
        r1       = fwd_hit1 ? bus.fwd_data : bus.rs1_data;
        r2       = fwd_hit2 ? bus.fwd_data : bus.rs2_data;
    end
`else
    // Forwarding disabled: register-file data is used as read.
    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                          bus.rs1_addr, bus.rs2_addr};

    always_comb begin
        r1 = bus.rs1_data;
        r2 = bus.rs2_data;
    end
`endif

    // Operand selection; code 3 on either select yields zero by design.
    always_comb begin
        req = '0;
        unique case (bus.a_sel)
            2'd0:    req.a = r1;
            2'd1:    req.a = bus.pc;
            default: req.a = '0;
        endcase
        unique case (bus.b_sel)
            2'd0:    req.b = r2;
            2'd1:    req.b = bus.imm;
            2'd2:    req.b = CONST_FOUR;
            default: req.b = '0;
        endcase
        req.sd = r2;
    end

    // in_ready only looks at SKID so it never depends on out_ready combinationally.
    assign bus.in_ready = !rst && (occ_q != OCC_TWO);
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = (occ_q != OCC_EMPTY) && bus.out_ready;

    // Next-state for occupancy and the OUT/SKID registers; flush drops everything
    // including a simultaneous request, while the OUT data simply holds.
    always_comb begin
        occ_d  = occ_q;
        out_d  = out_q;
        skid_d = skid_q;
        if (bus.flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_d = req;
                        occ_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && transfer) begin
                        out_d = req;
                    end else if (accept) begin
                        skid_d = req;
                        occ_d  = OCC_TWO;
                    end else if (transfer) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (transfer) begin
                        out_d = skid_q;
                        occ_d = OCC_ONE;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over flush and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign bus.out_valid  = (occ_q != OCC_EMPTY);
    assign bus.A          = out_q.a;
    assign bus.B          = out_q.b;
    assign bus.store_data = out_q.sd;

endmodule
